// File: rtl/m_bldcm_period2freq.sv
// m_bldcm_period2freq
// Measures the spacing of commutation phase steps and converts it back into a
// frequency value: freq = (pFreqClock / pTotalPhaseStages) / period.
// A 32-cycle restoring divider does the conversion. One further period can be
// queued while a division runs; the latest queued step wins. A long silence
// reports the motor as stopped.
module m_bldcm_period2freq #(
  parameter logic [31:0] pFreqClock        = 32'd50000000,
  parameter logic [3:0]  pTotalPhaseStages = 4'd12,
  parameter logic [31:0] pTimeoutCycles    = 32'd50000000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iPhaseStep,
  output logic [31:0] oFreqMeasured,
  output logic        oUpdated,
  output logic        oValid,
  output logic        oTimeout,
  output logic        oBusy
);

  // Numerator of every division, fixed at elaboration.
  localparam logic [31:0] K = pFreqClock / {28'd0, pTotalPhaseStages};

  typedef enum logic [1:0] {
    S_ARM = 2'd0,  // waiting for a first step to anchor the period counter
    S_RUN = 2'd1,  // counting a period, divider idle
    S_DIV = 2'd2   // divider running
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // cycles since the last step, saturating
  logic [31:0] pend_q, pend_d;        // queued period
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] den_q, den_d;          // divisor (captured period)
  logic [31:0] rem_q, rem_d;          // partial remainder
  logic [31:0] quo_q, quo_d;          // numerator shifting out / quotient shifting in
  logic [4:0]  iter_q, iter_d;        // iteration index of the running division
  logic [31:0] freq_q, freq_d;
  logic        upd_q, upd_d;
  logic        valid_q, valid_d;
  logic        tmo_q, tmo_d;
  logic        busy_q, busy_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic        load_en;
  logic [31:0] load_p;
  logic        timeout_hit;

  // One restoring-division iteration: shift in the next numerator bit and
  // subtract the divisor when it fits (diff[32] is the borrow).
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, den_q};
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
  end

  // Period counter: restarts at 1 on a step, otherwise counts up to the timeout.
  always_comb begin
    if (iPhaseStep) begin
      cnt_d = 32'd1;
    end else if (cnt_q >= pTimeoutCycles) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Sequencing: arm, capture periods, run and chain divisions, detect timeout.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would otherwise infer a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    den_d       = den_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    iter_d      = iter_q;
    freq_d      = freq_q;
    upd_d       = 1'b0;
    valid_d     = valid_q;
    tmo_d       = tmo_q;
    load_en     = 1'b0;
    load_p      = cnt_q;
    // A step on the timeout cycle is a real period and takes priority.
    timeout_hit = (state_q != S_ARM) && !iPhaseStep && (cnt_q >= pTimeoutCycles);

    case (state_q)
      S_ARM: begin
        if (iPhaseStep) state_d = S_RUN;
      end
      S_RUN: begin
        if (iPhaseStep) load_en = 1'b1;
      end
      S_DIV: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          freq_d  = quo_nx;
          upd_d   = 1'b1;
          valid_d = 1'b1;
          tmo_d   = 1'b0;
          if (iPhaseStep) begin
            // A step on the completion cycle is the newest period; it
            // supersedes anything queued.
            load_en    = 1'b1;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            load_en    = 1'b1;
            load_p     = pend_q;
            pend_vld_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else if (iPhaseStep) begin
          pend_d     = cnt_q;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = S_ARM;
    endcase

    // The period is always >= 1 here, so a zero divisor is never loaded.
    if (load_en) begin
      den_d   = load_p;
      rem_d   = '0;
      quo_d   = K;
      iter_d  = '0;
      state_d = S_DIV;
    end

    if (timeout_hit) begin
      state_d    = S_ARM;
      pend_vld_d = 1'b0;
      freq_d     = '0;
      upd_d      = 1'b1;
      valid_d    = 1'b0;
      tmo_d      = 1'b1;
    end

    busy_d = (state_d == S_DIV);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (iReset) begin
      state_q    <= S_ARM;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      // NOTE: the divider datapath is cleared as well; it is only a handful of
      // flops and keeps post-reset state fully deterministic.
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      iter_q     <= '0;
      freq_q     <= '0;
      upd_q      <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      iter_q     <= iter_d;
      freq_q     <= freq_d;
      upd_q      <= upd_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
    end
  end

  assign oFreqMeasured = freq_q;
  assign oUpdated      = upd_q;
  assign oValid        = valid_q;
  assign oTimeout      = tmo_q;
  assign oBusy         = busy_q;

endmodule

// File: tb/tb_m_bldcm_period2freq.sv
// Testbench for m_bldcm_period2freq with K = 1200/12 = 100 and a timeout of
// 1000 cycles. A timestamp-based model predicts every output on every cycle;
// directed scenarios add hand-computed expectations on top.
module tb_m_bldcm_period2freq;

  localparam int K  = 100;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic [31:0] freq;
  logic        upd, valid, tmo, busy;

  m_bldcm_period2freq #(
    .pFreqClock       (32'd1200),
    .pTotalPhaseStages(4'd12),
    .pTimeoutCycles   (32'd1000)
  ) dut (
    .iClock       (clk),
    .iReset       (rst),
    .iPhaseStep   (step),
    .oFreqMeasured(freq),
    .oUpdated     (upd),
    .oValid       (valid),
    .oTimeout     (tmo),
    .oBusy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on edge timestamps: a division started at edge c publishes K/P at
  // edge c+32. m_arm means no anchor step yet; m_div means a result is owed.
  int          cyc = 0;
  int          m_last = 0;
  int          m_done = 0;
  int          m_res = 0;
  int          m_pend_p = 0;
  int          p;
  bit          m_arm = 1'b1;
  bit          m_div = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] e_freq = '0;
  logic        e_upd = 1'b0, e_valid = 1'b0, e_tmo = 1'b1, e_busy = 1'b0;

  task automatic m_start(input int per);
    m_div  = 1'b1;
    m_done = cyc + 32;
    m_res  = K / per;
  endtask

  always @(posedge clk) begin
    cyc++;
    e_upd = 1'b0;
    if (rst) begin
      m_arm = 1'b1; m_div = 1'b0; m_pend = 1'b0;
      e_freq = '0; e_valid = 1'b0; e_tmo = 1'b1;
    end else begin
      p = cyc - m_last;
      if (p > TO) p = TO;
      if (!m_arm && !step && (cyc - m_last) >= TO) begin
        e_freq = '0; e_upd = 1'b1; e_tmo = 1'b1; e_valid = 1'b0;
        m_arm = 1'b1; m_div = 1'b0; m_pend = 1'b0;
      end else if (m_div && cyc == m_done) begin
        e_freq = 32'(m_res); e_upd = 1'b1; e_valid = 1'b1; e_tmo = 1'b0;
        m_div = 1'b0;
        if (step) begin
          m_start(p); m_pend = 1'b0;
        end else if (m_pend) begin
          m_start(m_pend_p); m_pend = 1'b0;
        end
      end else if (m_div) begin
        if (step) begin m_pend = 1'b1; m_pend_p = p; end
      end else if (m_arm) begin
        if (step) m_arm = 1'b0;
      end else if (step) begin
        m_start(p);
      end
      if (step) m_last = cyc;
    end
    e_busy = m_div;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("freq",  freq,      e_freq);
      check("upd",   32'(upd),  32'(e_upd));
      check("valid", 32'(valid), 32'(e_valid));
      check("tmo",   32'(tmo),  32'(e_tmo));
      check("busy",  32'(busy), 32'(e_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    @(negedge clk); rst = 1'b1; step = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Pulse a step 'gap' cycles after the previous driven cycle.
  task automatic step_after(input int gap);
    for (int i = 0; i < gap - 1; i++) begin @(negedge clk); step = 1'b0; end
    @(negedge clk); step = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); step = 1'b0; end
  endtask

  // Wait (bounded) for an oUpdated pulse; n = cycles waited.
  task automatic wait_upd(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk); step = 1'b0; n++;
    end while (!upd && n < budget);
    check("upd_seen", 32'(upd), 32'd1);
  endtask

  // Count oUpdated pulses over n idle cycles.
  task automatic count_upd(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); step = 1'b0;
      if (upd) cnt++;
    end
  endtask

  int n, cnt, r, gap;

  initial begin
    reset_dut();
    chk_en = 1'b1;
    check("rst_freq",  freq, 32'd0);
    check("rst_tmo",   32'(tmo), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);

    // 1: first step only arms; second, 10 later, gives 100/10 = 10 after 33.
    step_after(3);
    step_after(10);
    wait_upd(100, n);
    check("t1_latency", 32'(n), 32'd33);
    check("t1_freq",    freq, 32'd10);
    check("t1_valid",   32'(valid), 32'd1);
    check("t1_tmo",     32'(tmo), 32'd0);

    // 2: periods 3 then 1 -> 33 then 100, second via the pending register.
    reset_dut();
    step_after(2);
    step_after(3);
    step_after(1);
    wait_upd(100, n);
    check("t2_lat_a",  32'(n), 32'd32);
    check("t2_freq_a", freq, 32'd33);
    check("t2_busy",   32'(busy), 32'd1);
    wait_upd(100, n);
    check("t2_lat_b",  32'(n), 32'd32);
    check("t2_freq_b", freq, 32'd100);

    // 3: period 200 truncates to 0 but is still a valid measurement.
    step_after(5);
    step_after(200);
    wait_upd(100, n);
    check("t3_freq",  freq, 32'd0);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_tmo",   32'(tmo), 32'd0);

    // 4: steps every 2 cycles during a division -> exactly two results of 50.
    reset_dut();
    step_after(3);
    step_after(2); step_after(2); step_after(2); step_after(2);
    wait_upd(100, n);
    check("t4_freq_a", freq, 32'd50);
    wait_upd(100, n);
    check("t4_freq_b", freq, 32'd50);
    count_upd(40, cnt);
    check("t4_extra", 32'(cnt), 32'd0);

    // 5: running at period 10, then silence -> a single timeout update.
    step_after(10); step_after(10); step_after(10);
    idle(100);
    check("t5_freq", freq, 32'd10);
    wait_upd(1100, n);
    check("t5_to_freq",  freq, 32'd0);
    check("t5_to_tmo",   32'(tmo), 32'd1);
    check("t5_to_valid", 32'(valid), 32'd0);
    step_after(5);
    count_upd(40, cnt);
    check("t5_arm_upd", 32'(cnt), 32'd0);

    // 6: reset 15 cycles into a division -> reset values, no result later.
    step_after(20);
    idle(15);
    reset_dut();
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_upd",   32'(upd), 32'd0);
    check("t6_tmo",   32'(tmo), 32'd1);
    check("t6_valid", 32'(valid), 32'd0);
    count_upd(60, cnt);
    check("t6_no_res", 32'(cnt), 32'd0);

    // Randomised step spacing, including timeout-boundary gaps and resets.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        reset_dut();
      end else begin
        if (r < 7)       gap = int'($urandom_range(995, 1005));
        else if (r < 20) gap = int'($urandom_range(80, 400));
        else             gap = int'($urandom_range(1, 40));
        step_after(gap);
      end
    end
    idle(1100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
